// File: rtl/pk_extractor_pkg.sv
// Shared sizing helpers, default-configuration constants and FSM states for the public-key extractor.
package pk_extractor_pkg;

  function automatic int calc_wpr(input int cols, input int w);
    return (cols + w - 1) / w;
  endfunction

  function automatic int calc_opr(input int rows, input int cols, input int w);
    return (cols - rows + w - 1) / w;
  endfunction

  function automatic int calc_b(input int rows, input int w);
    return rows / w;
  endfunction

  function automatic int calc_off(input int rows, input int w);
    return rows % w;
  endfunction

  function automatic int calc_aw(input int rows, input int cols, input int w);
    int n;
    n = rows * calc_wpr(cols, w);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n + 1) : 1;
  endfunction

  localparam int ROWS_DEF = 6;
  localparam int COLS_DEF = 20;
  localparam int W_DEF    = 8;
  localparam int WPR      = calc_wpr(COLS_DEF, W_DEF);
  localparam int OPR      = calc_opr(ROWS_DEF, COLS_DEF, W_DEF);
  localparam int B        = calc_b(ROWS_DEF, W_DEF);
  localparam int OFF      = calc_off(ROWS_DEF, W_DEF);
  localparam int AW       = calc_aw(ROWS_DEF, COLS_DEF, W_DEF);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WT,
    EMIT,
    FLUSH,
    FIN
  } pk_state_e;

endpackage

// File: rtl/pk_extractor_if.sv
// Valid/ready output stream carrying public-key words; out_last marks the final word of the key.
interface pk_extractor_if #(
  parameter int W = 8
);
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/pk_word_align.sv
// Funnel-shifts two adjacent row words into one parity word and zeroes bits beyond the last column.
// Purely combinational; no backpressure of its own.
module pk_word_align
  import pk_extractor_pkg::*;
#(
  parameter int ROWS = 6,
  parameter int COLS = 20,
  parameter int W    = 8,
  parameter int KW   = 2
) (
  input  logic [W-1:0]  lo_i,
  input  logic [W-1:0]  hi_i,
  input  logic [KW-1:0] k_i,
  output logic [W-1:0]  dat_o
);
  localparam int OFF_C = calc_off(ROWS, W);

  logic [2*W-1:0] shifted;
  logic           unused_upper;

  assign shifted      = {hi_i, lo_i} >> OFF_C;
  assign unused_upper = ^shifted[2*W-1:W];

  // Output bit j of word k is matrix column ROWS + k*W + j.
  always_comb begin
    dat_o = '0;
    for (int j = 0; j < W; j++) begin
      if (ROWS + int'(k_i) * W + j < COLS) dat_o[j] = shifted[j];
    end
  end
endmodule

// File: rtl/pk_extractor.sv
// Reads a systemized matrix row by row, checks its identity block and streams the parity columns as W-bit words.
// Two cycles per RAM read; a pending output word stalls all further reads until out_ready.
module pk_extractor
  import pk_extractor_pkg::*;
#(
  parameter int  ROWS = 6,
  parameter int  COLS = 20,
  parameter int  W    = 8,
  localparam int AW_C = calc_aw(ROWS, COLS, W)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            done,
  output logic            fail,
  output logic            mem_rd_en,
  output logic [AW_C-1:0] mem_rd_addr,
  input  logic [W-1:0]    mem_rd_data,
  pk_extractor_if.master  out_if
);
  localparam int WPR_C = calc_wpr(COLS, W);
  localparam int OPR_C = calc_opr(ROWS, COLS, W);
  localparam int B_C   = calc_b(ROWS, W);
  localparam int RW    = cnt_w(ROWS);
  localparam int WW    = cnt_w(WPR_C);
  localparam int KW    = cnt_w(OPR_C);

  pk_state_e     state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [WW-1:0] wrd_q, wrd_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  prev_q, prev_d;
  logic [W-1:0]  cur_q, cur_d;
  logic          fail_q, fail_d;
  logic          row_end;
  logic          id_err;
  logic [W-1:0]  lo, hi, aligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      wrd_q   <= '0;
      k_q     <= '0;
      prev_q  <= '0;
      cur_q   <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      wrd_q   <= wrd_d;
      k_q     <= k_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      fail_q  <= fail_d;
    end
  end

  // Identity columns of the current row must read as the unit vector e_row.
  always_comb begin
    id_err = 1'b0;
    for (int b = 0; b < W; b++) begin
      if (int'(wrd_q) * W + b < ROWS) begin
        if (mem_rd_data[b] != (int'(wrd_q) * W + b == int'(row_q))) id_err = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    wrd_d   = wrd_q;
    k_d     = k_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    fail_d  = fail_q;
    row_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD;
          row_d   = '0;
          wrd_d   = '0;
          k_d     = '0;
          fail_d  = 1'b0;
        end
      end
      RD: state_d = WT;
      WT: begin
        prev_d = cur_q;
        cur_d  = mem_rd_data;
        if (id_err) fail_d = 1'b1;
        if (int'(wrd_q) >= B_C + 1) begin
          state_d = EMIT;
        end else if (int'(wrd_q) == WPR_C - 1) begin
          state_d = FLUSH;
        end else begin
          wrd_d   = wrd_q + WW'(1);
          state_d = RD;
        end
      end
      EMIT: begin
        if (out_if.out_ready) begin
          k_d = k_q + KW'(1);
          if (int'(wrd_q) == WPR_C - 1) begin
            if (int'(k_q) + 1 < OPR_C) state_d = FLUSH;
            else row_end = 1'b1;
          end else begin
            wrd_d   = wrd_q + WW'(1);
            state_d = RD;
          end
        end
      end
      FLUSH: begin
        // Past the last stored word both halves of the funnel read as zero.
        if (out_if.out_ready) begin
          k_d   = k_q + KW'(1);
          cur_d = '0;
          if (int'(k_q) + 1 >= OPR_C) row_end = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (row_end) begin
      wrd_d = '0;
      k_d   = '0;
      if (int'(row_q) == ROWS - 1) begin
        state_d = FIN;
      end else begin
        row_d   = row_q + RW'(1);
        state_d = RD;
      end
    end
  end

  assign lo = (state_q == FLUSH) ? cur_q : prev_q;
  assign hi = (state_q == FLUSH) ? '0 : cur_q;

  pk_word_align #(
    .ROWS (ROWS),
    .COLS (COLS),
    .W    (W),
    .KW   (KW)
  ) u_align (
    .lo_i  (lo),
    .hi_i  (hi),
    .k_i   (k_q),
    .dat_o (aligned)
  );

  assign mem_rd_en        = (state_q == RD);
  assign mem_rd_addr      = AW_C'(int'(row_q) * WPR_C + int'(wrd_q));
  assign done             = (state_q == FIN);
  assign fail             = fail_q;
  assign out_if.out_valid = (state_q == EMIT) || (state_q == FLUSH);
  assign out_if.out_data  = aligned;
  assign out_if.out_last  = out_if.out_valid && (int'(row_q) == ROWS - 1) &&
                            (int'(k_q) == OPR_C - 1);
endmodule

// File: tb/tb_pk_extractor.sv
// Scoreboarded bench for pk_extractor: default 6x20 configuration plus an 8x24 byte-aligned instance.
module tb_pk_extractor;
  import pk_extractor_pkg::*;

  localparam int AWB = calc_aw(8, 24, 8);
  localparam logic [13:0] PAR [6] = '{14'h1A5C, 14'h2F03, 14'h0BEE, 14'h3C71, 14'h1234, 14'h3FFF};
  localparam logic [7:0]  BW1 [8] = '{8'h3C, 8'hA5, 8'h0F, 8'hF0, 8'h69, 8'h96, 8'hC3, 8'h5A};
  localparam logic [7:0]  BW2 [8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hFF, 8'h00, 8'h7E, 8'hE7};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           start_a, done_a, fail_a, rd_en_a;
  logic [AW-1:0]  rd_addr_a;
  logic [7:0]     rd_data_a;
  logic           start_b, done_b, fail_b, rd_en_b;
  logic [AWB-1:0] rd_addr_b;
  logic [7:0]     rd_data_b;

  pk_extractor_if #(.W(8)) ifa ();
  pk_extractor_if #(.W(8)) ifb ();

  pk_extractor dut_a (
    .clk         (clk),
    .rst         (rst),
    .start       (start_a),
    .done        (done_a),
    .fail        (fail_a),
    .mem_rd_en   (rd_en_a),
    .mem_rd_addr (rd_addr_a),
    .mem_rd_data (rd_data_a),
    .out_if      (ifa)
  );

  pk_extractor #(.ROWS(8), .COLS(24), .W(8)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .start       (start_b),
    .done        (done_b),
    .fail        (fail_b),
    .mem_rd_en   (rd_en_b),
    .mem_rd_addr (rd_addr_b),
    .mem_rd_data (rd_data_b),
    .out_if      (ifb)
  );

  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];

  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
    if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
  end

  int checks = 0;
  int errors = 0;
  int rd_cnt_a = 0, exp_addr_a = 0, words_a = 0;
  int rd_cnt_b = 0, exp_addr_b = 0, words_b = 0;
  int rdy_mode = 0;
  logic [8:0] qa [$];
  logic [8:0] qb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  initial begin : rdy_drv
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ifa.out_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : mon_a
    logic       hold_v;
    logic [8:0] hold, got, e;
    hold_v = 1'b0;
    hold   = '0;
    forever begin
      @(negedge clk);
      got = {ifa.out_last, ifa.out_data};
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (rd_en_a) begin
          chk("a_rd_addr", 32'(rd_addr_a), 32'(exp_addr_a));
          exp_addr_a++;
          rd_cnt_a++;
        end
        if (hold_v) begin
          if (ifa.out_valid) chk("a_stall_stable", 32'(got), 32'(hold));
          else begin
            flag("a_valid_dropped");
            hold_v = 1'b0;
          end
        end
        if (ifa.out_valid && ifa.out_ready) begin
          hold_v = 1'b0;
          if (qa.size() == 0) flag("a_extra_word");
          else begin
            e = qa.pop_front();
            chk("a_word", 32'(got), 32'(e));
            words_a++;
          end
        end else if (ifa.out_valid) begin
          hold_v = 1'b1;
          hold   = got;
        end
      end
    end
  end

  initial begin : mon_b
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rd_en_b) begin
          chk("b_rd_addr", 32'(rd_addr_b), 32'(exp_addr_b));
          exp_addr_b++;
          rd_cnt_b++;
        end
        if (ifb.out_valid && ifb.out_ready) begin
          if (qb.size() == 0) flag("b_extra_word");
          else begin
            e = qb.pop_front();
            chk("b_word", 32'({ifb.out_last, ifb.out_data}), 32'(e));
            words_b++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Row r: identity e_r in cols 0..5, parity PAR[r] in cols 6..19, pad in cols 20..23.
  task automatic load_a(input logic [3:0] pad, input int bad_row, input int bad_bit);
    for (int r = 0; r < 6; r++) begin
      logic [13:0] p;
      p = PAR[r];
      mem_a[r*3]   = {p[1:0], 6'(1 << r)};
      mem_a[r*3+1] = p[9:2];
      mem_a[r*3+2] = {pad, p[13:10]};
    end
    if (bad_row >= 0) mem_a[bad_row*3][bad_bit] = 1'b0;
  endtask

  task automatic push_a();
    for (int r = 0; r < 6; r++) begin
      logic [13:0] p;
      p = PAR[r];
      qa.push_back({1'b0, p[7:0]});
      qa.push_back({(r == 5), 2'b00, p[13:8]});
    end
  endtask

  task automatic pulse_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_reads_a(input int n, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (rd_cnt_a >= n) seen = 1'b1;
    end
  endtask

  task automatic run_a(input int mode, input bit exp_fail, input bit mid_start);
    bit seen;
    push_a();
    rdy_mode   = mode;
    exp_addr_a = 0;
    rd_cnt_a   = 0;
    words_a    = 0;
    pulse_a();
    @(negedge clk);
    chk("a_fail_clear_on_start", 32'(fail_a), 32'(0));
    if (mid_start) begin
      wait_reads_a(10, seen);
      if (!seen) flag("a_mid_reads_timeout");
      pulse_a();
    end
    seen = 1'b0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      @(negedge clk);
      if (done_a) seen = 1'b1;
    end
    if (!seen) flag("a_done_timeout");
    chk("a_fail_at_done", 32'(fail_a), 32'(exp_fail));
    chk("a_reads", 32'(rd_cnt_a), 32'(18));
    chk("a_words", 32'(words_a), 32'(12));
    chk("a_queue_empty", 32'(qa.size()), 32'(0));
    @(negedge clk);
    chk("a_done_one_pulse", 32'(done_a), 32'(0));
    chk("a_fail_held", 32'(fail_a), 32'(exp_fail));
    qa.delete();
  endtask

  initial begin : stim
    bit seen;
    int snap;
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    load_a(4'h0, -1, 0);
    for (int r = 0; r < 8; r++) begin
      mem_b[r*3]   = 8'(1 << r);
      mem_b[r*3+1] = BW1[r];
      mem_b[r*3+2] = BW2[r];
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_done_a", 32'(done_a), 32'(0));
    chk("rst_fail_a", 32'(fail_a), 32'(0));
    chk("rst_rd_en_a", 32'(rd_en_a), 32'(0));
    chk("rst_valid_a", 32'(ifa.out_valid), 32'(0));
    chk("rst_last_a", 32'(ifa.out_last), 32'(0));
    chk("rst_done_b", 32'(done_b), 32'(0));
    chk("rst_valid_b", 32'(ifb.out_valid), 32'(0));

    run_a(0, 1'b0, 1'b0);          // clean matrix, ready held high
    load_a(4'h0, 3, 3);
    run_a(0, 1'b1, 1'b0);          // row 3 identity bit cleared
    load_a(4'h0, -1, 0);
    run_a(1, 1'b0, 1'b0);          // random ready, fail must clear
    load_a(4'hF, -1, 0);
    run_a(1, 1'b0, 1'b0);          // garbage in padding columns

    // Reset during row 2 with a corrupted row 0 so fail is already set.
    load_a(4'h0, 0, 0);
    push_a();
    rdy_mode   = 0;
    exp_addr_a = 0;
    rd_cnt_a   = 0;
    pulse_a();
    wait_reads_a(7, seen);
    if (!seen) flag("r_row2_timeout");
    chk("r_fail_before_rst", 32'(fail_a), 32'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    qa.delete();
    @(negedge clk);
    chk("r_done", 32'(done_a), 32'(0));
    chk("r_fail", 32'(fail_a), 32'(0));
    chk("r_rd_en", 32'(rd_en_a), 32'(0));
    chk("r_valid", 32'(ifa.out_valid), 32'(0));
    chk("r_last", 32'(ifa.out_last), 32'(0));
    snap = rd_cnt_a;
    repeat (4) @(negedge clk);
    chk("r_idle_no_reads", 32'(rd_cnt_a), 32'(snap));
    load_a(4'h0, -1, 0);
    run_a(0, 1'b0, 1'b1);          // full run from row 0, mid-run start ignored

    // Byte-aligned instance: parity words are memory words 1 and 2 verbatim.
    for (int r = 0; r < 8; r++) begin
      qb.push_back({1'b0, BW1[r]});
      qb.push_back({(r == 7), BW2[r]});
    end
    exp_addr_b = 0;
    rd_cnt_b   = 0;
    words_b    = 0;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      @(negedge clk);
      if (done_b) seen = 1'b1;
    end
    if (!seen) flag("b_done_timeout");
    chk("b_fail_at_done", 32'(fail_b), 32'(0));
    chk("b_reads", 32'(rd_cnt_b), 32'(24));
    chk("b_words", 32'(words_b), 32'(16));
    chk("b_queue_empty", 32'(qb.size()), 32'(0));
    @(negedge clk);
    chk("b_done_one_pulse", 32'(done_b), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
